// File: rtl/lc3b_dmem_responder.sv
// Fixed-latency data-memory model for the LC-3b datapath.
// One transaction is in flight at a time. Byte-lane writes are supported, and reads complete with a registered rdata value.
module lc3b_dmem_responder #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_mem_address,
    input  logic [15:0] d_mem_wdata,
    input  logic        d_mem_read,
    input  logic        d_mem_write,
    input  logic [1:0]  d_mem_byte_enable,
    output logic [15:0] d_mem_rdata,
    output logic        d_mem_resp,
    output logic        d_mem_stall
);

    localparam int unsigned WORDS = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned LOAD  = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [ADDR_BITS-1:0] hold_idx;
    logic [15:0]          hold_wdata;
    logic [1:0]           hold_be;
    logic                 hold_read;
    logic                 hold_write;

    logic [15:0] mem [WORDS];

    logic                 req_c;
    logic                 enter_resp_c;
    logic [ADDR_BITS-1:0] txn_idx_c;
    logic [15:0]          txn_wdata_c;
    logic [1:0]           txn_be_c;
    logic                 txn_read_c;
    logic                 txn_write_c;
    logic                 unused_addr_bits;

    assign req_c = d_mem_read | d_mem_write;

    // With LATENCY=1 the completing edge is also the accepting edge, so take the live inputs.
    assign txn_idx_c   = (state == IDLE) ? d_mem_address[ADDR_BITS:1] : hold_idx;
    assign txn_wdata_c = (state == IDLE) ? d_mem_wdata : hold_wdata;
    assign txn_be_c    = (state == IDLE) ? d_mem_byte_enable : hold_be;
    assign txn_read_c  = (state == IDLE) ? d_mem_read : hold_read;
    assign txn_write_c = (state == IDLE) ? (d_mem_write & ~d_mem_read) : hold_write;

    assign enter_resp_c = ((state == IDLE) && req_c && (LATENCY == 1)) ||
                          ((state == BUSY) && (count == '0));

    assign d_mem_stall = req_c & ~d_mem_resp;

    assign unused_addr_bits = ^{d_mem_address[0], d_mem_address >> (ADDR_BITS + 1)};

    // Transaction FSM, holding registers and read-data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            d_mem_resp  <= 1'b0;
            d_mem_rdata <= 16'h0000;
            hold_idx    <= '0;
            hold_wdata  <= '0;
            hold_be     <= '0;
            hold_read   <= 1'b0;
            hold_write  <= 1'b0;
        end else begin
            d_mem_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_c) begin
                        hold_idx   <= d_mem_address[ADDR_BITS:1];
                        hold_wdata <= d_mem_wdata;
                        hold_be    <= d_mem_byte_enable;
                        hold_read  <= d_mem_read;
                        hold_write <= d_mem_write & ~d_mem_read;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            d_mem_resp <= 1'b1;
                        end else begin
                            state <= BUSY;
                            count <= CNT_W'(LOAD);
                        end
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state      <= RESP;
                        d_mem_resp <= 1'b1;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp_c && txn_read_c) begin
                d_mem_rdata <= mem[txn_idx_c];
            end
        end
    end

    // Storage is never cleared. A reset on the completing edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp_c && txn_write_c) begin
            if (txn_be_c[0]) mem[txn_idx_c][7:0]  <= txn_wdata_c[7:0];
            if (txn_be_c[1]) mem[txn_idx_c][15:8] <= txn_wdata_c[15:8];
        end
    end

endmodule

// File: tb/tb_lc3b_dmem_responder.sv
// Scoreboard bench for lc3b_dmem_responder (LATENCY=2, ADDR_BITS=8).
module tb_lc3b_dmem_responder;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_mem_address;
    logic [15:0] d_mem_wdata;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] d_mem_rdata;
    logic        d_mem_resp;
    logic        d_mem_stall;

    lc3b_dmem_responder #(.LATENCY(LAT), .ADDR_BITS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .d_mem_address     (d_mem_address),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_byte_enable (d_mem_byte_enable),
        .d_mem_rdata       (d_mem_rdata),
        .d_mem_resp        (d_mem_resp),
        .d_mem_stall       (d_mem_stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          exp_cyc;
        logic [15:0] exp_rdata;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        head;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_rd = 16'h0000;
    int          base;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest expected entry in cycle and data.
    always @(negedge clk) begin
        if (d_mem_resp === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got resp at cycle %0d expected none", cyc);
            end else begin
                head = sb.pop_front();
                check_val({head.name, "_cycle"}, 32'(cyc), 32'(head.exp_cyc));
                check_val({head.name, "_rdata"}, 32'(d_mem_rdata), 32'(head.exp_rdata));
            end
        end
    end

    task automatic wait_resp(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            seen = (d_mem_resp === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: got no resp expected resp within 12 cycles", name);
        end
    endtask

    task automatic txn(input string name, input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be, input logic [15:0] exp_rd);
        exp_t e;
        @(negedge clk);
        d_mem_read        = rd;
        d_mem_write       = wr;
        d_mem_address     = addr;
        d_mem_wdata       = wdata;
        d_mem_byte_enable = be;
        @(posedge clk);
        #1;
        if (rd) last_rd = exp_rd;
        e.exp_cyc   = cyc + int'(LAT) - 1;
        e.exp_rdata = last_rd;
        e.name      = name;
        sb.push_back(e);
        // Scramble the request inputs; the in-flight transaction must ignore them.
        d_mem_read        = 1'b0;
        d_mem_write       = 1'b0;
        d_mem_address     = 16'($urandom);
        d_mem_wdata       = 16'($urandom);
        d_mem_byte_enable = 2'($urandom);
        wait_resp(name);
    endtask

    initial begin
        exp_t e;
        rst               = 1'b1;
        d_mem_read        = 1'b0;
        d_mem_write       = 1'b0;
        d_mem_address     = 16'h0000;
        d_mem_wdata       = 16'h0000;
        d_mem_byte_enable = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_resp", 32'(d_mem_resp), 32'd0);
        check_val("reset_rdata", 32'(d_mem_rdata), 32'h0000);
        check_val("reset_stall", 32'(d_mem_stall), 32'd0);
        rst = 1'b0;

        txn("wr_beef", 1'b1 ^ 1'b1, 1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000);
        txn("rd_beef", 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF);

        txn("wr_1234", 1'b0, 1'b1, 16'h0020, 16'h1234, 2'b11, 16'h0000);
        txn("wr_ab_hi", 1'b0, 1'b1, 16'h0020, 16'hAB00, 2'b10, 16'h0000);
        txn("wr_cd_lo", 1'b0, 1'b1, 16'h0020, 16'h00CD, 2'b01, 16'h0000);
        txn("rd_abcd", 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00, 16'hABCD);
        txn("wr_be00", 1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, 16'h0000);
        txn("rd_odd_addr", 1'b1, 1'b0, 16'h0021, 16'h0000, 2'b00, 16'hABCD);

        txn("wr_wrap", 1'b0, 1'b1, 16'h0201, 16'h5555, 2'b11, 16'h0000);
        txn("rd_wrap", 1'b1, 1'b0, 16'h0000, 16'h0000, 2'b00, 16'h5555);

        // Continuous read: one response every LAT+1 cycles, stall high otherwise.
        @(negedge clk);
        d_mem_read    = 1'b1;
        d_mem_address = 16'h0020;
        @(posedge clk);
        #1;
        base    = cyc;
        last_rd = 16'hABCD;
        for (int n = 0; n < 3; n++) begin
            e.exp_cyc   = base + 1 + 3 * n;
            e.exp_rdata = 16'hABCD;
            e.name      = $sformatf("held_rd%0d", n);
            sb.push_back(e);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_val($sformatf("held_stall%0d", k), 32'(d_mem_stall),
                      32'((k == 1 || k == 4 || k == 7) ? 0 : 1));
        end
        d_mem_read = 1'b0;

        // Reset on the edge that would enter RESP aborts the write.
        txn("wr_ffff", 1'b0, 1'b1, 16'h0030, 16'hFFFF, 2'b11, 16'h0000);
        @(negedge clk);
        d_mem_write       = 1'b1;
        d_mem_address     = 16'h0030;
        d_mem_wdata       = 16'h0000;
        d_mem_byte_enable = 2'b11;
        @(posedge clk);
        #1;
        d_mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_resp", 32'(d_mem_resp), 32'd0);
        check_val("abort_rdata", 32'(d_mem_rdata), 32'h0000);
        last_rd = 16'h0000;
        txn("rd_after_abort", 1'b1, 1'b0, 16'h0030, 16'h0000, 2'b00, 16'hFFFF);

        // Read and write together behave as a read.
        txn("wr_1357", 1'b0, 1'b1, 16'h0040, 16'h1357, 2'b11, 16'h0000);
        txn("rdwr_both", 1'b1, 1'b1, 16'h0040, 16'h9999, 2'b11, 16'h1357);
        txn("rd_after_both", 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b00, 16'h1357);

        repeat (4) @(negedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lc3b_dmem_responder.md
LC3B_DMEM_RESPONDER -- requirements
Module: lc3b_dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter ADDR_BITS, default 8, word-index width; storage is 2**ADDR_BITS 16-bit words.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 d_mem_address  input  16  byte address from the datapath; bit 0 ignored.
REQ-006 d_mem_wdata  input  16  write data.
REQ-007 d_mem_read  input  1  read request.
REQ-008 d_mem_write  input  1  write request.
REQ-009 d_mem_byte_enable  input  2  write byte lanes: [0] = bits 7:0, [1] = bits 15:8.
REQ-010 d_mem_rdata  output  16  read data.
REQ-011 d_mem_resp  output  1  one-cycle completion pulse.
REQ-012 d_mem_stall  output  1  pipeline hold request, combinational.

Function
REQ-013 FSM states: IDLE, BUSY, RESP; a request is accepted only when the state is IDLE.
REQ-014 IDLE: at a rising edge with d_mem_read or d_mem_write high, capture the address, wdata, byte_enable and op into holding registers.
REQ-015 IDLE -> RESP when LATENCY=1; otherwise IDLE -> BUSY with the down-counter loaded to LATENCY-2.
REQ-016 BUSY: decrement the counter each cycle; BUSY -> RESP when the counter is 0.
REQ-017 RESP lasts exactly one cycle, then returns to IDLE; d_mem_resp = 1 only in RESP.
REQ-018 Timing: if a request is accepted at the edge that ends cycle T, d_mem_resp is high in cycle T+LATENCY.
REQ-019 Word index = captured address[ADDR_BITS:1]; higher address bits are ignored, so addresses wrap modulo 2**(ADDR_BITS+1) bytes.
REQ-020 Write: at the edge entering RESP, update only the byte lanes enabled in the captured byte_enable; byte_enable = 00 still completes with a response but changes no storage.
REQ-021 Read: at the edge entering RESP, load d_mem_rdata with the full stored word.
REQ-022 d_mem_rdata holds its value until the next read completes; writes do not alter it.
REQ-023 If read and write are both high at acceptance, the transaction is a read; no storage change.
REQ-024 Request inputs that change after acceptance have no effect on the transaction in flight.
REQ-025 A request held high through RESP is re-accepted in the following IDLE cycle, so back-to-back transactions repeat every LATENCY+1 cycles.
REQ-026 A write followed by a read of the same word returns the written data; there is no stale-read window.
REQ-027 d_mem_stall = (d_mem_read | d_mem_write) & ~d_mem_resp.

Reset
REQ-028 rst high at an edge sets: state IDLE, counter 0, d_mem_resp 0, d_mem_rdata 16'h0000, holding registers 0.
REQ-029 Reset mid-transaction aborts it: no storage write and no response, even when rst coincides with the edge entering RESP.
REQ-030 Storage contents are not cleared by reset.
REQ-031 A request present in the cycle after rst deasserts is accepted normally.

Verification (LATENCY=2, ADDR_BITS=8)
REQ-032 Write 16'hBEEF to 0x0010 with be=11, then read 0x0010 -> each resp high exactly 2 cycles after acceptance; rdata=16'hBEEF.
REQ-033 Write 16'h1234 to 0x0020 with be=11; write 16'hAB00 with be=10; write 16'h00CD with be=01; read 0x0020 -> 16'hABCD.
REQ-034 Write 16'h5555 to 0x0201; read 0x0000 -> 16'h5555 (bit 0 and bits above 8 ignored).
REQ-035 Hold d_mem_read high continuously -> resp pulses every 3 cycles; stall is high in all other cycles.
REQ-036 Write 16'hFFFF to 0x0030; accept a write of 16'h0000 to 0x0030 and assert rst at the edge entering RESP; read 0x0030 -> 16'hFFFF, and no resp occurred for the aborted write.
REQ-037 Read and write both high at 0x0040 with wdata 16'h9999 -> read response; a later read of 0x0040 shows the prior contents unchanged.
